// File: rtl/mmio_calc_master.sv
// Memory-mapped calculator master: reads an opcode and an operand from two input
// ports, runs one ALU step on a persistent accumulator, then writes the result and status out.
module mmio_calc_master (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [31:0] a,
   output logic        we,
   output logic [31:0] wd,
   input  logic [31:0] rd,
   output logic [15:0] acc
);

   localparam logic [31:0] PORTA_RD = 32'h0000_FF00;
   localparam logic [31:0] PORTB_RD = 32'h0000_FF10;
   localparam logic [31:0] PORTC_WR = 32'h0000_7F20;
   localparam logic [31:0] PORTD_WR = 32'h0000_7FFC;

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_B,
      EXEC,
      WR_C,
      WR_D,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [15:0] opnd_q, opnd_d;
   logic [15:0] acc_q, acc_d;
   logic        c_q, c_d;
   logic        z_q, z_d;
   logic        inv_q, inv_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [16:0] sum;
   logic [31:0] prod;
   logic        unused_rd;

   // The operand port is 16 bits wide; its upper half is deliberately dropped.
   assign unused_rd = ^rd[31:16];
   assign acc       = acc_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= 4'h0;
         opnd_q  <= 16'h0000;
         acc_q   <= 16'h0000;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         inv_q   <= 1'b0;
         cnt_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         c_q     <= c_d;
         z_q     <= z_d;
         inv_q   <= inv_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      c_d     = c_q;
      z_d     = z_q;
      inv_d   = inv_q;
      cnt_d   = cnt_q;
      busy    = 1'b1;
      done    = 1'b0;
      a       = 32'h0000_0000;
      we      = 1'b0;
      wd      = 32'h0000_0000;
      sum     = {1'b0, acc_q} + {1'b0, opnd_q};
      prod    = {16'h0000, acc_q} * {16'h0000, opnd_q};

      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d = RD_A;
            end
         end
         RD_A: begin
            a       = PORTA_RD;
            op_d    = rd[3:0];
            state_d = RD_B;
         end
         RD_B: begin
            a       = PORTB_RD;
            opnd_d  = rd[15:0];
            state_d = EXEC;
         end
         EXEC: begin
            inv_d = 1'b0;
            case (op_q)
               4'd0: begin
                  acc_d = 16'h0000;
                  c_d   = 1'b0;
               end
               4'd1: begin
                  acc_d = sum[15:0];
                  c_d   = sum[16];
               end
               4'd2: begin
                  acc_d = acc_q - opnd_q;
                  c_d   = (opnd_q > acc_q);
               end
               4'd3: begin
                  acc_d = prod[15:0];
                  c_d   = (prod[31:16] != 16'h0000);
               end
               4'd4: begin
                  acc_d = opnd_q;
                  c_d   = 1'b0;
               end
               default: begin
                  c_d   = 1'b0;
                  inv_d = 1'b1;
               end
            endcase
            z_d     = (acc_d == 16'h0000);
            state_d = WR_C;
         end
         WR_C: begin
            a       = PORTC_WR;
            we      = 1'b1;
            wd      = {16'h0000, acc_q};
            state_d = WR_D;
         end
         // The status word carries the count before this transaction is tallied.
         WR_D: begin
            a       = PORTD_WR;
            we      = 1'b1;
            wd      = {16'h0000, cnt_q, 5'b00000, z_q, inv_q, c_q};
            cnt_d   = cnt_q + 8'd1;
            state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mmio_calc_master.sv
// Self-checking bench for mmio_calc_master: a bus responder supplies the input ports and a
// negedge monitor compares every bus write against a queue of predicted writes.
module tb_mmio_calc_master;

   localparam logic [31:0] PORTA_RD = 32'h0000_FF00;
   localparam logic [31:0] PORTB_RD = 32'h0000_FF10;
   localparam logic [31:0] PORTC_WR = 32'h0000_7F20;
   localparam logic [31:0] PORTD_WR = 32'h0000_7FFC;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        done;
   logic [31:0] a;
   logic        we;
   logic [31:0] wd;
   logic [31:0] rd;
   logic [15:0] acc;

   logic [31:0] portA;
   logic [31:0] portB;
   logic [31:0] lastWd;
   logic [63:0] expQ[$];
   logic [15:0] modelAcc;
   logic        modelC;
   logic        modelZ;
   logic        modelInv;
   logic [7:0]  modelCnt;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // Unmapped addresses return a recognisable pattern so a wrong read address shows up.
   assign rd = (a == PORTA_RD) ? portA : ((a == PORTB_RD) ? portB : 32'h5A5A_5A5A);

   mmio_calc_master dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .busy  (busy),
      .done  (done),
      .a     (a),
      .we    (we),
      .wd    (wd),
      .rd    (rd),
      .acc   (acc)
   );

   // Every bus write must match the oldest predicted write still outstanding.
   always @(negedge clk) begin
      if (we === 1'b1) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_write got a=%h wd=%h, no write expected", a, wd);
         end else begin
            logic [63:0] e;
            e = expQ.pop_front();
            if ({a, wd} !== e) begin
               errors++;
               $display("[TB] FAIL bus_write got a=%h wd=%h, expected a=%h wd=%h", a, wd, e[63:32], e[31:0]);
            end
         end
         lastWd = wd;
      end
   end

   task automatic predictTxn(input logic [3:0] op, input logic [15:0] opnd, input bit withWrD);
      logic [16:0] s;
      logic [31:0] p;
      s = {1'b0, modelAcc} + {1'b0, opnd};
      p = {16'h0000, modelAcc} * {16'h0000, opnd};
      modelInv = 1'b0;
      case (op)
         4'd0: begin modelAcc = 16'h0000; modelC = 1'b0; end
         4'd1: begin modelAcc = s[15:0]; modelC = s[16]; end
         4'd2: begin modelC = (opnd > modelAcc); modelAcc = modelAcc - opnd; end
         4'd3: begin modelAcc = p[15:0]; modelC = (p[31:16] != 16'h0000); end
         4'd4: begin modelAcc = opnd; modelC = 1'b0; end
         default: begin modelC = 1'b0; modelInv = 1'b1; end
      endcase
      modelZ = (modelAcc == 16'h0000);
      expQ.push_back({PORTC_WR, 16'h0000, modelAcc});
      if (withWrD) begin
         expQ.push_back({PORTD_WR, 16'h0000, modelCnt, 5'b00000, modelZ, modelInv, modelC});
         modelCnt = modelCnt + 8'd1;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [15:0] opnd);
      bit seen;
      @(negedge clk);
      portA = {28'hC0FFEE5, op};
      portB = {16'hBEEF, opnd};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      predictTxn(op, opnd, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL done_timeout got no done pulse, expected done within 12 cycles");
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, we, a, wd, acc} !== 83'h0) begin
         errors++;
         $display("[TB] FAIL reset_state got busy=%b done=%b we=%b a=%h wd=%h acc=%h, expected all zero", busy, done, we, a, wd, acc);
      end
      reset = 1'b0;
      start = 1'b0;
      modelAcc = 16'h0; modelC = 1'b0; modelZ = 1'b0; modelInv = 1'b0; modelCnt = 8'h0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_priority got busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_load_add();
      applyStimulus(4'd4, 16'd100);
      applyStimulus(4'd1, 16'd23);
      checks++;
      if (acc !== 16'h007B) begin
         errors++;
         $display("[TB] FAIL load_add_acc got %h, expected 007b", acc);
      end
      checks++;
      if (lastWd !== 32'h0000_0100) begin
         errors++;
         $display("[TB] FAIL load_add_status got %h, expected 00000100", lastWd);
      end
   endtask

   task automatic test_add_overflow();
      applyStimulus(4'd4, 16'hFFFF);
      applyStimulus(4'd1, 16'h0002);
      checks++;
      if (acc !== 16'h0001 || lastWd[0] !== 1'b1 || lastWd[2] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL add_overflow got acc=%h C=%b Z=%b, expected acc=0001 C=1 Z=0", acc, lastWd[0], lastWd[2]);
      end
   endtask

   task automatic test_sub();
      applyStimulus(4'd4, 16'd5);
      applyStimulus(4'd2, 16'd5);
      checks++;
      if (acc !== 16'h0000 || lastWd[2:0] !== 3'b100) begin
         errors++;
         $display("[TB] FAIL sub_zero got acc=%h ZIC=%b, expected acc=0000 ZIC=100", acc, lastWd[2:0]);
      end
      applyStimulus(4'd2, 16'd1);
      checks++;
      if (acc !== 16'hFFFF || lastWd[2:0] !== 3'b001) begin
         errors++;
         $display("[TB] FAIL sub_wrap got acc=%h ZIC=%b, expected acc=ffff ZIC=001", acc, lastWd[2:0]);
      end
   endtask

   task automatic test_mul_inv();
      applyStimulus(4'd4, 16'h0100);
      applyStimulus(4'd3, 16'h0100);
      checks++;
      if (acc !== 16'h0000 || lastWd[2:0] !== 3'b101) begin
         errors++;
         $display("[TB] FAIL mul_overflow got acc=%h ZIC=%b, expected acc=0000 ZIC=101", acc, lastWd[2:0]);
      end
      applyStimulus(4'd9, 16'h1234);
      checks++;
      if (acc !== 16'h0000 || lastWd[2:0] !== 3'b110) begin
         errors++;
         $display("[TB] FAIL invalid_op got acc=%h ZIC=%b, expected acc=0000 ZIC=110", acc, lastWd[2:0]);
      end
   endtask

   task automatic test_timing();
      @(negedge clk);
      portA = 32'h0000_0004;
      portB = 32'h0000_1234;
      start = 1'b1;
      predictTxn(4'd4, 16'h1234, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== (i <= 6) || we !== (i == 4 || i == 5) || done !== (i == 6)) begin
            errors++;
            $display("[TB] FAIL timing_cycle%0d got busy=%b we=%b done=%b, expected busy=%b we=%b done=%b", i, busy, we, done, (i <= 6), (i == 4 || i == 5), (i == 6));
         end
         start = (i == 2 || i == 3);
      end
      start = 1'b0;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      portA = 32'h0000_0001;
      portB = 32'h0000_0001;
      start = 1'b1;
      predictTxn(4'd1, 16'h0001, 1'b1);
      predictTxn(4'd1, 16'h0001, 1'b1);
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (i == 8) start = 1'b0;
         checks++;
         if (done !== (i == 6 || i == 13) || busy !== !(i == 7 || i == 14 || i == 15)) begin
            errors++;
            $display("[TB] FAIL back_to_back_cycle%0d got done=%b busy=%b, expected done=%b busy=%b", i, done, busy, (i == 6 || i == 13), !(i == 7 || i == 14 || i == 15));
         end
      end
   endtask

   task automatic test_reset_midop();
      @(negedge clk);
      portA = 32'h0000_0001;
      portB = 32'h0000_0007;
      start = 1'b1;
      predictTxn(4'd1, 16'h0007, 1'b0);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (we !== 1'b1 || a !== PORTC_WR) begin
         errors++;
         $display("[TB] FAIL midop_in_wrc got we=%b a=%h, expected we=1 a=%h", we, a, PORTC_WR);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (we !== 1'b0 || busy !== 1'b0 || acc !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL midop_abort got we=%b busy=%b acc=%h, expected we=0 busy=0 acc=0000", we, busy, acc);
      end
      reset = 1'b0;
      modelAcc = 16'h0; modelC = 1'b0; modelZ = 1'b0; modelInv = 1'b0; modelCnt = 8'h0;
      repeat (3) @(negedge clk);
      applyStimulus(4'd4, 16'h0042);
      checks++;
      if (lastWd !== 32'h0000_0000) begin
         errors++;
         $display("[TB] FAIL midop_cnt_cleared got status=%h, expected 00000000", lastWd);
      end
   endtask

   task automatic test_cnt_wrap();
      for (int i = 0; i < 255; i++) begin
         applyStimulus(4'd0, 16'h0000);
      end
      checks++;
      if (lastWd !== 32'h0000_FF04) begin
         errors++;
         $display("[TB] FAIL cnt_max got status=%h, expected 0000ff04", lastWd);
      end
      applyStimulus(4'd0, 16'h0000);
      checks++;
      if (lastWd !== 32'h0000_0004) begin
         errors++;
         $display("[TB] FAIL cnt_wrap got status=%h, expected 00000004", lastWd);
      end
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      portA  = 32'h0;
      portB  = 32'h0;
      lastWd = 32'h0;
      test_reset();
      test_load_add();
      test_add_overflow();
      test_sub();
      test_mul_inv();
      test_timing();
      test_back_to_back();
      test_reset_midop();
      test_cnt_wrap();
      repeat (3) @(negedge clk);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL missing_writes got %0d writes outstanding, expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmio_calc_master.md
MMIO_CALC_MASTER -- requirements
Module: mmio_calc_master

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  rising-edge system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request one transaction; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion
- a  out  32  bus address to the data-memory/IO responder
- we  out  1  bus write enable; the responder writes on the rising edge
- wd  out  32  bus write data
- rd  in  32  bus read data; combinational from a, valid in the same cycle
- acc  out  16  current accumulator value (debug)
REQ-002 The block SHALL use one clock only; reset SHALL be synchronous and active-high.
REQ-003 The block SHALL use these fixed addresses:
- PORTA_RD = 0x0000FF00
- PORTB_RD = 0x0000FF10
- PORTC_WR = 0x00007F20
- PORTD_WR = 0x00007FFC

Function
REQ-004 The FSM SHALL have states IDLE, RD_A, RD_B, EXEC, WR_C, WR_D and DONE, with one state per cycle after leaving IDLE.
REQ-005 In IDLE with start=1, the next state SHALL be RD_A; with start=0 it SHALL stay IDLE; start SHALL be ignored in all other states.
REQ-006 RD_A SHALL drive a=PORTA_RD and we=0, and SHALL capture op=rd[3:0] at the clock edge.
REQ-007 RD_B SHALL drive a=PORTB_RD and we=0, and SHALL capture opnd=rd[15:0] at the clock edge; rd[31:16] SHALL be ignored.
REQ-008 EXEC SHALL drive we=0 and a=0, and SHALL update acc and the status flags at the clock edge:
- op 0: clear, acc=0
- op 1: add, acc=(acc+opnd) mod 2^16, C=17th bit
- op 2: sub, acc=(acc-opnd) mod 2^16, C=(opnd>acc)
- op 3: mul, acc=low 16 bits of the 32-bit product, C=(upper 16 bits != 0)
- op 4: load, acc=opnd, C=0
- op 5..15: acc unchanged, C=0, INV=1; INV=0 for ops 0..4
- Z=(new acc==0)
REQ-009 WR_C SHALL drive a=PORTC_WR, we=1, wd={16'h0000, acc}.
REQ-010 WR_D SHALL drive a=PORTD_WR, we=1, wd={16'h0000, cnt[7:0], 5'b0, Z, INV, C}.
REQ-011 cnt SHALL be an 8-bit transaction counter that increments at the WR_D edge, so the written value is the pre-increment count, and SHALL wrap 255->0.
REQ-012 DONE SHALL assert done=1 for exactly one cycle, drive we=0, and return to IDLE unconditionally.
REQ-013 In IDLE and DONE the block SHALL drive a=0, we=0, wd=0.
REQ-014 we SHALL be high only in WR_C and WR_D, for exactly one cycle each.
REQ-015 Latency SHALL be fixed: if start is sampled high at edge N, done SHALL be high during cycle N+6, and the earliest next start SHALL be accepted at edge N+7.
REQ-016 A start held high continuously SHALL produce back-to-back transactions every 7 cycles.
REQ-017 acc and the flags SHALL persist across transactions, so operations chain on the previous result.

Reset
REQ-018 Reset SHALL force state=IDLE, acc=0, op=0, opnd=0, C=Z=INV=0, cnt=0, busy=0, done=0, a=0, we=0, wd=0 at the next edge.
REQ-019 Reset asserted in any state, including WR_C/WR_D, SHALL abort the transaction; no further bus write SHALL occur after the reset edge.
REQ-020 Reset SHALL take priority over start in the same cycle.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Load then add: porta=4, portb=100, start; then porta=1, portb=23, start -> second WR_C wd=0x0000007B; WR_D wd=0x00000100 (cnt=1, flags 0).
- Add overflow: acc=0xFFFF, op=1, portb=2 -> acc=0x0001; WR_D bit0=1, bit2=0.
- Sub borrow to zero and wrap: acc=5, op=2, opnd=5 -> acc=0, Z=1, C=0; then opnd=1 -> acc=0xFFFF, C=1.
- Multiply and invalid: acc=0x0100, op=3, opnd=0x0100 -> acc=0x0000, C=1, Z=1; then op=9 -> acc unchanged, INV=1.
- Timing: single start pulse -> busy high for cycles N+1..N+6, we high exactly in cycles N+4 and N+5, done high only in cycle N+6; start pulses during busy are ignored.
- Reset mid-op: reset asserted during WR_C -> at the next edge we=0, busy=0, acc=0, cnt=0; the PORTD_WR write never occurs; 256 transactions -> cnt wraps to 0.
